// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding, FSM states, counter sizing.
package hilo_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MADDU = 3'd7;

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   // Step counter only needs to reach WIDTH-1.
   function automatic int unsigned calc_cnt_width(input int unsigned width);
      return (width > 1) ? int'($clog2(width)) : 1;
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative sign-magnitude engine: shift-add multiply or restoring divide, one bit per cycle,
// followed by a single sign-correction cycle during which done is high.
module muldiv_core
   import hilo_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               is_div,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] res
);

   localparam int unsigned CntW = calc_cnt_width(WIDTH);
   localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [WIDTH-1:0] acc_q, shr_q, opb_q;
   logic            is_div_q, neg_q_q, neg_r_q;

   logic [WIDTH-1:0] a_mag, b_mag, acc_d, shr_d, quot_fix, rem_fix;
   logic [WIDTH:0]   add_sum, shifted;
   logic             div_ge;
   logic [2*WIDTH-1:0] prod, prod_fix;

   assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

   // acc_q is the running high half (product) or partial remainder; shr_q holds the
   // multiplier being consumed LSB-first, or the dividend becoming the quotient.
   always_comb begin
      add_sum = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opb_q} : '0);
      shifted = {acc_q, shr_q[WIDTH-1]};
      div_ge  = shifted >= {1'b0, opb_q};
      acc_d   = add_sum[WIDTH:1];
      shr_d   = {add_sum[0], shr_q[WIDTH-1:1]};
      if (is_div_q) begin
         acc_d = div_ge ? WIDTH'(shifted - {1'b0, opb_q}) : shifted[WIDTH-1:0];
         shr_d = {shr_q[WIDTH-2:0], div_ge};
      end
   end

   always_comb begin
      prod     = {acc_q, shr_q};
      prod_fix = neg_q_q ? -prod : prod;
      quot_fix = neg_q_q ? -shr_q : shr_q;
      rem_fix  = neg_r_q ? -acc_q : acc_q;
      res      = is_div_q ? {rem_fix, quot_fix} : prod_fix;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         shr_q    <= '0;
         opb_q    <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q  <= StCalc;
                  busy     <= 1'b1;
                  cnt_q    <= '0;
                  acc_q    <= '0;
                  shr_q    <= is_div ? a_mag : b_mag;
                  opb_q    <= is_div ? b_mag : a_mag;
                  is_div_q <= is_div;
                  // A zero divisor leaves the all-ones quotient unsigned-looking.
                  neg_q_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & (|b);
                  neg_r_q  <= is_signed & a[WIDTH-1];
               end
            end
            StCalc: begin
               acc_q <= acc_d;
               shr_q <= shr_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastStep) begin
                  state_q <= StFix;
                  done    <= 1'b1;
               end
            end
            StFix: begin
               state_q <= StIdle;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with multi-cycle mul/div engine and MTHI/MTLO writes.
// Define HILO_MADD_EN to enable MADD/MADDU accumulate on ops 6/7.
module hilo_muldiv
   import hilo_pkg::*;
#(
   parameter int unsigned     WIDTH    = 32,
   parameter logic [WIDTH-1:0] HI_RESET = '0,
   parameter logic [WIDTH-1:0] LO_RESET = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [2*WIDTH-1:0] core_res, wr_val;
   logic               accept, is_md, is_div, is_signed, core_start;

   assign accept = start & ~busy;

   always_comb begin
      is_md = 1'b0;
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_md = 1'b1;
`ifdef HILO_MADD_EN
         OP_MADD, OP_MADDU: is_md = 1'b1;
`endif
         default: is_md = 1'b0;
      endcase
   end

   assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
   assign is_signed  = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
   assign core_start = accept & is_md;

   muldiv_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .start    (core_start),
      .is_div   (is_div),
      .is_signed(is_signed),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .res      (core_res)
   );

`ifdef HILO_MADD_EN
   logic madd_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         madd_q <= 1'b0;
      end else if (core_start) begin
         madd_q <= (op == OP_MADD) || (op == OP_MADDU);
      end
   end

   // Accumulates onto whatever HI/LO hold during the FIX cycle.
   assign wr_val = madd_q ? ({hi_q, lo_q} + core_res) : core_res;
`else
   assign wr_val = core_res;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= HI_RESET;
         lo_q <= LO_RESET;
      end else if (done) begin
         {hi_q, lo_q} <= wr_val;
      end else if (accept && op == OP_MTHI) begin
         hi_q <= a;
      end else if (accept && op == OP_MTLO) begin
         lo_q <= a;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed corner cases plus random ops against an
// arithmetic reference model. Honours HILO_MADD_EN when defined.
module tb_hilo_muldiv;
   import hilo_pkg::*;

   localparam int unsigned W = 32;
   localparam logic [W-1:0] HI_RST = 32'hC0DE_0001;
   localparam logic [W-1:0] LO_RST = 32'h0000_5A5A;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] mhi, mlo;

   hilo_muldiv #(
      .WIDTH   (W),
      .HI_RESET(HI_RST),
      .LO_RESET(LO_RST)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .op   (op),
      .a    (a),
      .b    (b),
      .busy (busy),
      .done (done),
      .hi   (hi),
      .lo   (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [2*W-1:0] product(input logic sgn, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
      longint sx, sy;
      if (sgn) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         return 64'(sx * sy);
      end
      return {32'b0, x} * {32'b0, y};
   endfunction

   // Reference: plain integer arithmetic on the architectural HI/LO state.
   task automatic model_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint sx, sy, q, r;
      logic [63:0] q64, r64;
      case (o)
         3'd0: {mhi, mlo} = product(1'b1, x, y);
         3'd1: {mhi, mlo} = product(1'b0, x, y);
         3'd2, 3'd3: begin
            if (y == 0) begin
               mlo = '1;
               mhi = x;
            end else begin
               if (o == 3'd2) begin
                  sx = longint'($signed(x));
                  sy = longint'($signed(y));
               end else begin
                  sx = longint'({32'b0, x});
                  sy = longint'({32'b0, y});
               end
               q = sx / sy;
               r = sx % sy;
               q64 = q;
               r64 = r;
               mlo = q64[W-1:0];
               mhi = r64[W-1:0];
            end
         end
         3'd4: mhi = x;
         3'd5: mlo = x;
`ifdef HILO_MADD_EN
         3'd6: {mhi, mlo} = {mhi, mlo} + product(1'b1, x, y);
         3'd7: {mhi, mlo} = {mhi, mlo} + product(1'b0, x, y);
`endif
         default: ;
      endcase
   endtask

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1;
      op = o;
      a = x;
      b = y;
      model_op(o, x, y);
      @(posedge clk);
      #1;
      start = 1'b0;
      a = $urandom;
      b = $urandom;
   endtask

   // Waits out a mul/div while poking ignored starts (MTHI 0xAAAA at step 3).
   task automatic wait_md();
      int c = 0;
      int ndone = 0;
      int done_c = -1;
      while (busy === 1'b1 && c < int'(W) + 8) begin
         if (done === 1'b1) begin
            ndone++;
            if (done_c < 0) done_c = c;
         end
         start = (c == 3) ? 1'b1 : 1'(($urandom_range(0, 1)));
         op = (c == 3) ? OP_MTHI : 3'($urandom_range(0, 7));
         a = (c == 3) ? 32'h0000_AAAA : $urandom;
         b = $urandom;
         @(posedge clk);
         #1;
         c++;
      end
      start = 1'b0;
      check("latency", c, W + 1);
      check("done_at", done_c, W);
      check("done_cnt", ndone, 1);
      check("done_low", {31'b0, done}, 0);
      check("hi", hi, mhi);
      check("lo", lo, mlo);
   endtask

   task automatic run_md(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      issue(o, x, y);
      wait_md();
   endtask

   task automatic run_idle(input logic [2:0] o, input logic [W-1:0] x);
      issue(o, x, $urandom);
      check("idle_busy", {31'b0, busy}, 0);
      check("idle_done", {31'b0, done}, 0);
      check("idle_hi", hi, mhi);
      check("idle_lo", lo, mlo);
   endtask

   initial begin
      logic [2:0]   o;
      logic [W-1:0] x, y;
      int           nd;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mhi = HI_RST;
      mlo = LO_RST;
      check("rst_hi", hi, HI_RST);
      check("rst_lo", lo, LO_RST);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done}, 0);

      run_md(OP_MULT, 32'hFFFF_FFFE, 32'd3);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFA);
      run_md(OP_DIVU, 32'd100, 32'd7);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);
      run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);
      run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      check("ovf_lo", lo, 32'h8000_0000);
      check("ovf_hi", hi, 32'h0);
      run_md(OP_DIVU, 32'h0000_1234, 32'h0);
      check("dz_lo", lo, 32'hFFFF_FFFF);
      check("dz_hi", hi, 32'h0000_1234);
      run_md(OP_DIV, 32'hFFFF_FF00, 32'h0);
      run_md(OP_MULTU, 32'd5, 32'd6);
      check("mtbusy_hi", hi, 32'h0);
      check("mtbusy_lo", lo, 32'd30);

      run_idle(OP_MTHI, 32'h1111_2222);
      run_idle(OP_MTLO, 32'h3333_4444);

`ifdef HILO_MADD_EN
      run_idle(OP_MTHI, 32'h0);
      run_idle(OP_MTLO, 32'hFFFF_FFFF);
      run_md(OP_MADDU, 32'd1, 32'd1);
      check("maddu_hi", hi, 32'd1);
      check("maddu_lo", lo, 32'd0);
      run_md(OP_MADD, 32'hFFFF_FFFD, 32'd7);
`else
      run_idle(OP_MADDU, 32'd1);
      run_idle(OP_MADD, 32'd5);
`endif

      for (int i = 0; i < 40; i++) begin
`ifdef HILO_MADD_EN
         o = 3'($urandom_range(0, 5));
         if (o > 3'd3) o = o + 3'd2;
`else
         o = 3'($urandom_range(0, 3));
`endif
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: y = '0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2: y = 32'($urandom_range(1, 20));
            3: x = 32'($urandom_range(0, 50));
            default: ;
         endcase
         run_md(o, x, y);
      end

      issue(OP_DIVU, 32'hFFFF_FFF0, 32'd3);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mhi = HI_RST;
      mlo = LO_RST;
      check("midrst_hi", hi, HI_RST);
      check("midrst_lo", lo, LO_RST);
      check("midrst_busy", {31'b0, busy}, 0);
      check("midrst_done", {31'b0, done}, 0);
      nd = 0;
      repeat (40) begin
         if (done === 1'b1) nd++;
         @(posedge clk);
         #1;
      end
      check("midrst_nodone", nd, 0);
      check("midrst_hold_hi", hi, HI_RST);
      run_md(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Parametrised successor to the single HI register: a combined HI/LO register pair with an iterative multi-cycle multiply/divide engine, plus MTHI/MTLO direct writes.
- Sits beside the CPU ALU.
- The decode stage issues ops and must stall while busy is high; MFHI/MFLO read hi/lo directly.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- HI_RESET, 0, reset value of HI (WIDTH bits).
- LO_RESET, 0, reset value of LO (WIDTH bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  op valid this cycle.
- op  in  3  operation select (encoding in package).
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b  in  WIDTH  rt operand: multiplier or divisor.
- busy  out  1  engine occupied; new start is ignored while high.
- done  out  1  one-cycle pulse on the cycle HI/LO take a mul/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (sync, active-high): hi=HI_RESET, lo=LO_RESET, busy=0, done=0, FSM to IDLE. Reset mid-operation abandons the calculation with no HI/LO write.
- Op codes:
  - 0 MULT: signed, {HI,LO} = a*b.
  - 1 MULTU: unsigned multiply.
  - 2 DIV: signed, LO = quotient, HI = remainder.
  - 3 DIVU: unsigned divide.
  - 4 MTHI: HI = a.
  - 5 MTLO: LO = a.
  - 6-7: reserved, ignored when HILO_MADD_EN is off.
- A start is accepted only when busy=0. A start while busy=1 is ignored entirely: no queueing, no effect on the current op.
- MTHI/MTLO: the register updates on the accepting edge. Visible next cycle. busy stays 0 and done is not pulsed.
- FSM states: IDLE, CALC, FIX.
  - IDLE -> CALC on accepted mul/div. On that edge, latch operand magnitudes (absolute values for signed ops) and result sign flags. busy=1 from the next cycle.
  - CALC runs exactly WIDTH cycles. Multiply: shift-add, one multiplier bit per cycle. Divide: restoring, one quotient bit per cycle.
  - FIX runs 1 cycle. It applies sign correction and writes HI/LO at the end of the cycle, with done=1 during FIX. The next state is IDLE.
  - busy is high in CALC and FIX.
- Latency: start accepted at edge N; new HI/LO visible after edge N+WIDTH+1. With WIDTH=32, that is 33 edges.
- Signed rules:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend; truncation toward zero.
  - Product is negative iff the signs differ, negated over 2*WIDTH bits.
- Divide by zero: LO = all ones, HI = a (dividend unchanged), signed or unsigned. Same latency.
- Signed overflow (a = most-negative, b = -1): LO = most-negative, HI = 0. This falls out of the magnitude algorithm and needs no special case.
- Operands are captured at accept; a/b changing during CALC has no effect.
- HI/LO hold their values whenever neither a write nor FIX occurs.

Optional Feature:
- Macro: HILO_MADD_EN.
- Defined:
  - op 6 = MADD (signed) and op 7 = MADDU: {HI,LO} = {HI,LO} + a*b modulo 2^(2*WIDTH).
  - Accumulate happens in FIX using the HI/LO values present at FIX.
  - Same latency as MULT.
- Undefined: ops 6/7 are ignored like any other reserved code, with no busy and no write. The accumulate adder is not synthesised.

Decomposition:
- Package hilo_pkg: op encoding constants (OP_MULT..OP_MADDU), the FSM state typedef, and CALC cycle-count width as a function of WIDTH.
- One sub-module, muldiv_core, is natural. It holds the iterative shift-add/restoring datapath, the step counter and the magnitude/sign handling.
- The top level keeps the HI/LO registers, accept logic, MT writes and the optional MADD accumulate.

Test Plan:
- Reset then MULT a=0xFFFFFFFE (-2), b=3 -> busy for 33 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU a=100, b=7 -> lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- Start MULTU 5*6, then MTHI a=0xAAAA at cycle 3 while busy -> MTHI ignored. Final hi=0, lo=30. MTHI then MTLO while idle -> hi/lo update the next cycle with no done pulse.
- Start DIVU, assert rst at CALC step 10 -> next cycle hi=HI_RESET, lo=LO_RESET, busy=0, and no done pulse ever follows.
- With HILO_MADD_EN: MTHI 0, MTLO 0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0. Without the macro, the same op 7 -> busy stays 0 and hi/lo are unchanged.
